pc_stack_param: RTL and testbench
=================================

Name: pc_stack_param

Overview:
- Parametrised LIFO return-address stack for the PIC-style core.
- Successor to the fixed 2-level, 9-bit stack.
- Single-cycle push (write and advance in one cycle) and pop, plus a replace-top operation.
- Occupancy count, full/empty status, and sticky overflow/underflow flags.
- Selectable wrap (PIC-compatible) or saturate behaviour at the limits.
- Sits between the program counter (push on CALL, pop on RETLW) and the control unit.

Parameters:
- DATA_W, 9, width of each stored return address.
- DEPTH, 2, number of levels; power of two, >= 2.
- WRAP_MODE, 1, 1 = circular pointer on overflow/underflow (PIC behaviour); 0 = saturate and ignore the offending operation.

Ports:
- clk  in  1  instruction-cycle clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  store push_data as the new top.
- pop  in  1  discard the current top.
- push_data  in  DATA_W  address from the PC.
- clr_flags  in  1  clears the sticky ovf/unf flags.
- top_data  out  DATA_W  current top of stack, to the PC.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky: a push was attempted while full.
- unf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is synchronous, active-high, and has priority over every other input.
  - Reset takes effect on the next rising edge, including mid-sequence.
  - After reset: pointer sp=0, count=0, all storage entries=0, top_data=0, empty=1, full=0, ovf=0, unf=0.
- Storage and pointer:
  - DEPTH x DATA_W registers; PTR_W=$clog2(DEPTH).
  - sp points to the next free slot and wraps modulo DEPTH.
- top_data:
  - top_data = mem[sp-1 mod DEPTH], driven combinationally from registered state.
  - Zero latency: the value is valid in the cycle after the push/pop edge.
- Push only, not full: mem[sp] <= push_data; sp+1; count+1.
- Push only, full:
  - WRAP_MODE=1: the oldest entry is overwritten (mem[sp] <= push_data), sp+1, count stays DEPTH, ovf <= 1.
  - WRAP_MODE=0: storage, sp and count unchanged; ovf <= 1.
- Pop only, not empty: sp-1; count-1. Stored data is not cleared.
- Pop only, empty:
  - WRAP_MODE=1: sp-1 (wraps), count stays 0, unf <= 1; top_data shows the stale entry.
  - WRAP_MODE=0: no change; unf <= 1.
- Push and pop together:
  - count>0: replace top. mem[sp-1] <= push_data; sp and count unchanged; no flag change.
  - count==0: treated as a plain push. Count becomes 1; unf not set.
- Flags:
  - ovf and unf hold until clr_flags or rst.
  - If clr_flags coincides with a new overflow/underflow event, the flag ends at 1 (set wins).
- Status outputs:
  - empty, full and count are registered, or derived combinationally from the registered count.
  - They always agree with count.
- Idle: no push and no pop means full hold.

Decomposition:
- Shared package pic_pkg:
  - PC_W=9 (default DATA_W).
  - STACK_DEPTH=2.
  - stack_op_e enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}, decoded internally from {push, pop}.
- No sub-module; a single module is sufficient.
- The sticky flag pair may be a local always block.

Test Plan:
1. Reset: rst=1 for 2 cycles -> count=0, empty=1, full=0, top_data=0, ovf=0, unf=0.
2. Push then pop (DEPTH=2, WRAP=1): push 0x0A3, push 0x1F0 -> full=1, top=0x1F0, count=2; pop -> top=0x0A3, count=1; pop -> empty=1, unf=0.
3. Overflow wrap (WRAP=1): push 0x001, 0x002, then 0x003 -> ovf=1, count=2, top=0x003; pop -> top=0x002; pop -> empty.
4. Saturate (WRAP=0): push 0x001 and 0x002, push 0x003 -> ovf=1, top=0x002; on empty, pop -> unf=1, count=0; clr_flags -> ovf=0, unf=0.
5. Replace and simultaneous ops: push 0x055, then push+pop with 0x0AA -> count=1, top=0x0AA; push+pop on empty with 0x111 -> count=1, top=0x111, unf=0.
6. Reset mid-operation, DEPTH=8: push 5 values, then assert rst together with push -> count=0, top=0, push ignored; clr_flags together with overflow -> ovf=1.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC-style core: default widths and the
// return-stack operation encoding.
package pic_pkg;

  localparam int PC_W        = 9;
  localparam int STACK_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // Push and pop together on an empty stack has nothing to replace,
  // so it is treated as a plain push.
  function automatic stack_op_e decode_op(input logic push,
                                          input logic pop,
                                          input logic is_empty);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = is_empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_param.sv
// Parametrised LIFO return-address stack with occupancy tracking, sticky
// overflow/underflow flags and selectable wrap or saturate behaviour.
module pc_stack_param
  import pic_pkg::*;
#(
  parameter int DATA_W    = PC_W,
  parameter int DEPTH     = STACK_DEPTH,
  parameter int WRAP_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       clr_flags,
  output logic [DATA_W-1:0]          top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_inc;
  logic [PTR_W-1:0]  sp_dec;
  logic [CNT_W-1:0]  cnt;
  stack_op_e         op;
  logic              ovf_event;
  logic              unf_event;

  // DEPTH is a power of two, so plain pointer arithmetic wraps modulo DEPTH.
  assign sp_inc = sp + PTR_W'(1);
  assign sp_dec = sp - PTR_W'(1);

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_FULL);
  assign count    = cnt;
  assign top_data = mem[sp_dec];

  assign op        = decode_op(push, pop, empty);
  assign ovf_event = (op == OP_PUSH) && full;
  assign unf_event = (op == OP_POP) && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (op)
        OP_PUSH: begin
          if (!full) begin
            mem[sp] <= push_data;
            sp      <= sp_inc;
            cnt     <= cnt + CNT_W'(1);
          end else if (WRAP_MODE != 0) begin
            // Overwrite the oldest entry, count stays at DEPTH.
            mem[sp] <= push_data;
            sp      <= sp_inc;
          end
        end
        OP_POP: begin
          if (!empty) begin
            sp  <= sp_dec;
            cnt <= cnt - CNT_W'(1);
          end else if (WRAP_MODE != 0) begin
            sp <= sp_dec;
          end
        end
        OP_REPLACE: mem[sp_dec] <= push_data;
        default: ;
      endcase
    end
  end

  // Sticky flags: a new event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_event)      ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (unf_event)      unf <= 1'b1;
      else if (clr_flags) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_stack_param.sv
// Self-checking bench for pc_stack_param: three configurations share one
// stimulus stream; directed tables plus a randomised model-based run.
module tb_pc_stack_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr_flags = 1'b0;
  logic [8:0] push_data = '0;

  logic [8:0] top_w2, top_s2, top_w8;
  logic [1:0] cnt_w2, cnt_s2;
  logic [3:0] cnt_w8;
  logic       empty_w2, full_w2, ovf_w2, unf_w2;
  logic       empty_s2, full_s2, ovf_s2, unf_s2;
  logic       empty_w8, full_w8, ovf_w8, unf_w8;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];

  typedef struct packed {
    logic        r;
    logic        pu;
    logic        po;
    logic        c;
    logic [8:0]  d;
    logic [16:0] e;
  } step_t;

  pc_stack_param #(.DATA_W(9), .DEPTH(2), .WRAP_MODE(1)) u_w2 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .top_data(top_w2), .count(cnt_w2),
    .empty(empty_w2), .full(full_w2), .ovf(ovf_w2), .unf(unf_w2)
  );

  pc_stack_param #(.DATA_W(9), .DEPTH(2), .WRAP_MODE(0)) u_s2 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .top_data(top_s2), .count(cnt_s2),
    .empty(empty_s2), .full(full_s2), .ovf(ovf_s2), .unf(unf_s2)
  );

  pc_stack_param #(.DATA_W(9), .DEPTH(8), .WRAP_MODE(1)) u_w8 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .top_data(top_w8), .count(cnt_w8),
    .empty(empty_w8), .full(full_w8), .ovf(ovf_w8), .unf(unf_w8)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Status packing: {top[8:0], count[3:0], empty, full, ovf, unf}
  function automatic logic [16:0] st(input logic [8:0] t, input int c,
                                     input bit e, input bit f,
                                     input bit o, input bit u);
    return {t, 4'(c), e, f, o, u};
  endfunction

  function automatic logic [16:0] obs(input int k);
    case (k)
      0:       return {top_w2, 4'(cnt_w2), empty_w2, full_w2, ovf_w2, unf_w2};
      1:       return {top_s2, 4'(cnt_s2), empty_s2, full_s2, ovf_s2, unf_s2};
      default: return {top_w8, cnt_w8, empty_w8, full_w8, ovf_w8, unf_w8};
    endcase
  endfunction

  function automatic step_t mk(input logic r, input logic pu, input logic po,
                               input logic c, input logic [8:0] d,
                               input logic [16:0] e);
    step_t s;
    s.r = r; s.pu = pu; s.po = po; s.c = c; s.d = d; s.e = e;
    return s;
  endfunction

  // Driver: apply inputs away from the edge, sample 1 time unit after it.
  task automatic cycle(input logic r, input logic pu, input logic po,
                       input logic c, input logic [8:0] d);
    rst = r; push = pu; pop = po; clr_flags = c; push_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] got, exp;
    cycle(0, 1, 0, 0, 9'h123);
    cycle(0, 1, 0, 0, 9'h045);
    cycle(0, 1, 0, 0, 9'h067);
    cycle(1, 0, 0, 0, 9'h000);
    cycle(1, 0, 0, 0, 9'h000);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(st(9'h000, 0, 1, 0, 0, 0));
      got = obs(k);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset inst %0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_push_pop();
    step_t t[$];
    logic [16:0] got, exp;
    t.push_back(mk(1, 0, 0, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h0A3, st(9'h0A3, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h1F0, st(9'h1F0, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 0, 0, 0, 9'h000, st(9'h1F0, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h0A3, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h1F0, 0, 1, 0, 0, 0)));
    foreach (t[i]) begin
      exp_q.push_back(t[i].e);
      cycle(t[i].r, t[i].pu, t[i].po, t[i].c, t[i].d);
      got = obs(0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL push_pop step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    step_t t[$];
    logic [16:0] got, exp;
    t.push_back(mk(1, 0, 0, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h001, st(9'h001, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h002, st(9'h002, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h003, st(9'h003, 2, 0, 1, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h002, 1, 0, 0, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h003, 0, 1, 0, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h002, 0, 1, 0, 1, 1)));
    t.push_back(mk(0, 0, 0, 1, 9'h000, st(9'h002, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 0, 1, 1, 9'h000, st(9'h003, 0, 1, 0, 0, 1)));
    foreach (t[i]) begin
      exp_q.push_back(t[i].e);
      cycle(t[i].r, t[i].pu, t[i].po, t[i].c, t[i].d);
      got = obs(0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow_wrap step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    step_t t[$];
    logic [16:0] got, exp;
    t.push_back(mk(1, 0, 0, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h001, st(9'h001, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h002, st(9'h002, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h003, st(9'h002, 2, 0, 1, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h001, 1, 0, 0, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h002, 0, 1, 0, 1, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h002, 0, 1, 0, 1, 1)));
    t.push_back(mk(0, 0, 0, 1, 9'h000, st(9'h002, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h004, st(9'h004, 1, 0, 0, 0, 0)));
    foreach (t[i]) begin
      exp_q.push_back(t[i].e);
      cycle(t[i].r, t[i].pu, t[i].po, t[i].c, t[i].d);
      got = obs(1);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturate step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_replace();
    step_t t[$];
    logic [16:0] got, exp;
    t.push_back(mk(1, 0, 0, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h055, st(9'h055, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, 1, 0, 9'h0AA, st(9'h0AA, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    t.push_back(mk(0, 1, 1, 0, 9'h111, st(9'h111, 1, 0, 0, 0, 0)));
    t.push_back(mk(0, 1, 0, 0, 9'h022, st(9'h022, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 1, 1, 0, 9'h033, st(9'h033, 2, 0, 1, 0, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h111, 1, 0, 0, 0, 0)));
    foreach (t[i]) begin
      exp_q.push_back(t[i].e);
      cycle(t[i].r, t[i].pu, t[i].po, t[i].c, t[i].d);
      got = obs(0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL replace step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step_t t[$];
    logic [16:0] got, exp;
    t.push_back(mk(1, 0, 0, 0, 9'h000, st(9'h000, 0, 1, 0, 0, 0)));
    for (int v = 0; v < 5; v++)
      t.push_back(mk(0, 1, 0, 0, 9'(16 + v), st(9'(16 + v), v + 1, 0, 0, 0, 0)));
    t.push_back(mk(1, 1, 0, 0, 9'h099, st(9'h000, 0, 1, 0, 0, 0)));
    for (int v = 0; v < 8; v++)
      t.push_back(mk(0, 1, 0, 0, 9'(32 + v), st(9'(32 + v), v + 1, 0, v == 7, 0, 0)));
    t.push_back(mk(0, 1, 0, 1, 9'h1FF, st(9'h1FF, 8, 0, 1, 1, 0)));
    t.push_back(mk(0, 0, 0, 1, 9'h000, st(9'h1FF, 8, 0, 1, 0, 0)));
    t.push_back(mk(0, 0, 1, 0, 9'h000, st(9'h027, 7, 0, 0, 0, 0)));
    foreach (t[i]) begin
      exp_q.push_back(t[i].e);
      cycle(t[i].r, t[i].pu, t[i].po, t[i].c, t[i].d);
      got = obs(2);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_op step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  // Reference model for the randomised run, one slot per instance.
  logic [8:0] m_mem [3][8];
  int         m_sp  [3];
  int         m_cnt [3];
  bit         m_ovf [3];
  bit         m_unf [3];
  int         dep   [3] = '{2, 2, 8};
  bit         wr    [3] = '{1'b1, 1'b0, 1'b1};

  task automatic model_step(input int k, input bit r, input bit pu,
                            input bit po, input bit c, input logic [8:0] d);
    bit oe, ue;
    oe = 0;
    ue = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
      m_sp[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      return;
    end
    if (pu && po && m_cnt[k] > 0) begin
      m_mem[k][(m_sp[k] + dep[k] - 1) % dep[k]] = d;
    end else if (pu) begin
      if (m_cnt[k] < dep[k]) begin
        m_mem[k][m_sp[k]] = d;
        m_sp[k] = (m_sp[k] + 1) % dep[k];
        m_cnt[k]++;
      end else begin
        oe = 1;
        if (wr[k]) begin
          m_mem[k][m_sp[k]] = d;
          m_sp[k] = (m_sp[k] + 1) % dep[k];
        end
      end
    end else if (po) begin
      if (m_cnt[k] > 0) begin
        m_sp[k] = (m_sp[k] + dep[k] - 1) % dep[k];
        m_cnt[k]--;
      end else begin
        ue = 1;
        if (wr[k]) m_sp[k] = (m_sp[k] + dep[k] - 1) % dep[k];
      end
    end
    m_ovf[k] = oe | (m_ovf[k] & !c);
    m_unf[k] = ue | (m_unf[k] & !c);
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    bit r, pu, po, c;
    logic [8:0] d;
    for (int n = 0; n < 400; n++) begin
      r  = (n == 0) || ($urandom_range(0, 49) == 0);
      pu = $urandom_range(0, 1);
      po = $urandom_range(0, 1);
      c  = ($urandom_range(0, 9) == 0);
      d  = 9'($urandom_range(0, 511));
      for (int k = 0; k < 3; k++) begin
        model_step(k, r, pu, po, c, d);
        exp_q.push_back(st(m_mem[k][(m_sp[k] + dep[k] - 1) % dep[k]], m_cnt[k],
                           m_cnt[k] == 0, m_cnt[k] == dep[k], m_ovf[k], m_unf[k]));
      end
      cycle(r, pu, po, c, d);
      for (int k = 0; k < 3; k++) begin
        got = obs(k);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random cycle %0d inst %0d: got %h expected %h", n, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_push_pop();
    test_overflow_wrap();
    test_saturate();
    test_replace();
    test_reset_mid_op();
    test_random();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
